z80_io_master: RTL

- Z80-style I/O bus initiator; drives the same port-level bus that the VDP's CPU interface decodes (A, iorq_n, rd_n, wr_n, cd).
- Converts a single-beat valid/ready request (port address, read/write, data) into a timed Z80 I/O cycle (T1, T2, TW..., T3) and returns read data or completion.
- Used by on-FPGA host sequencers and self-test logic to program the VDP through its external port path, and as a synthesizable bus driver in benches.

---
 rtl/z80_io_master.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/z80_io_master.sv
// ----------------------------------------------------------------------------
// z80_io_master
//
// Z80-style I/O bus initiator. Takes a single-beat valid/ready request
// (port address, direction, write data) and plays it out on the port-level
// bus as a timed Z80 I/O cycle: T1, T2, zero or more TW, T3. Each T-state
// lasts T_CLKS clocks. A read returns the sampled data bus; every cycle ends
// with a one-clock completion pulse.
//
// Parameters
//   T_CLKS        clocks per T-state (2..63)
//   WAIT_STATES   automatic TW states per cycle (0..7)
//   WAIT_TIMEOUT  max TW states added by wait_n before forced completion
//                 (1..1023)
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_write             1 = OUT cycle, 0 = IN cycle
//   req_addr, req_wdata   port address and write data, latched on accept
//   rsp_valid             one-clock completion pulse
//   rsp_rdata             read data (meaningful for reads when rsp_valid)
//   rsp_err               wait timeout flag, qualified by rsp_valid
//   wait_n                bus wait request, active low, synchronous to clk
//   A                     address bus
//   iorq_n, rd_n, wr_n    bus strobes, active low
//   cd_out, cd_oe         data bus drive value and enable
//   cd_in                 data bus input
// ----------------------------------------------------------------------------
module z80_io_master #(
    parameter int T_CLKS       = 6,
    parameter int WAIT_STATES  = 1,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    input  logic       wait_n,
    output logic [7:0] A,
    output logic       iorq_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic [7:0] cd_out,
    output logic       cd_oe,
    input  logic [7:0] cd_in
);

    // Index of the last clock inside a T-state.
    localparam logic [5:0] CNT_LAST     = 6'(T_CLKS - 1);
    // Index of the last T3 clock with strobes still low (T3 cycle H, H = T_CLKS/2).
    localparam logic [5:0] CNT_HOLD     = 6'((T_CLKS / 2) - 1);
    localparam logic [2:0] TW_AUTO      = 3'(WAIT_STATES);
    localparam logic [9:0] TW_MAX_EXTRA = 10'(WAIT_TIMEOUT);

    // ST_RESET only lasts while reset is applied and for the clock it is
    // released on, so that req_ready stays low throughout reset.
    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_T1,
        ST_T2,
        ST_TW,
        ST_T3
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [2:0] tw_left_q, tw_left_d;
    logic [9:0] extra_q, extra_d;

    logic       write_q, write_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;

    logic [7:0] a_q, a_d;
    logic       iorq_n_q, iorq_n_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic [7:0] cd_out_q, cd_out_d;
    logic       cd_oe_q, cd_oe_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       rsp_err_q, rsp_err_d;

    logic       cnt_last;
    logic       bus_active;
    logic       strobe;

    always_comb begin
        state_d     = state_q;
        tw_left_d   = tw_left_q;
        extra_d     = extra_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        cnt_last = (cnt_q == CNT_LAST);
        cnt_d    = cnt_last ? 6'd0 : cnt_q + 6'd1;

        case (state_q)
            ST_RESET: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end

            ST_IDLE: begin
                cnt_d = 6'd0;
                if (req_valid) begin
                    state_d   = ST_T1;
                    write_d   = req_write;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    tw_left_d = TW_AUTO;
                    extra_d   = 10'd0;
                    rsp_err_d = 1'b0;
                end
            end

            ST_T1: begin
                if (cnt_last) begin
                    state_d = ST_T2;
                end
            end

            ST_T2: begin
                if (cnt_last) begin
                    state_d = (WAIT_STATES == 0) ? ST_T3 : ST_TW;
                end
            end

            // At the end of every TW, a low wait_n appends one more TW
            // until the extension budget is spent; after that the cycle is
            // forced to finish and flagged as a timeout.
            ST_TW: begin
                if (cnt_last) begin
                    if (!wait_n) begin
                        if (extra_q == TW_MAX_EXTRA) begin
                            state_d   = ST_T3;
                            rsp_err_d = 1'b1;
                        end else begin
                            extra_d = extra_q + 10'd1;
                        end
                    end else if (tw_left_q > 3'd1) begin
                        tw_left_d = tw_left_q - 3'd1;
                    end else begin
                        state_d = ST_T3;
                    end
                end
            end

            ST_T3: begin
                if (cnt_last) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 6'd0;
            end
        endcase

        rsp_valid_d = (state_q == ST_T3) && cnt_last;

        // Last clock with rd_n low: capture the bus as it closes.
        if ((state_q == ST_T3) && (cnt_q == CNT_HOLD) && !write_q) begin
            rsp_rdata_d = cd_in;
        end

        // Bus outputs are registered from the next state so that they line
        // up exactly with the T-state they belong to.
        bus_active = (state_d == ST_T1) || (state_d == ST_T2) ||
                     (state_d == ST_TW) || (state_d == ST_T3);
        strobe     = (state_d == ST_T2) || (state_d == ST_TW) ||
                     ((state_d == ST_T3) && (cnt_d <= CNT_HOLD));

        a_d      = bus_active ? addr_d : 8'h00;
        cd_oe_d  = bus_active && write_d;
        cd_out_d = cd_oe_d ? wdata_d : 8'h00;
        iorq_n_d = !strobe;
        rd_n_d   = !(strobe && !write_d);
        wr_n_d   = !(strobe && write_d);
    end

    // Single state/output register bank; reset releases the strobes and the
    // data bus at once and discards any request in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_RESET;
            cnt_q       <= 6'd0;
            tw_left_q   <= 3'd0;
            extra_q     <= 10'd0;
            write_q     <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            a_q         <= 8'h00;
            iorq_n_q    <= 1'b1;
            rd_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            cd_out_q    <= 8'h00;
            cd_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tw_left_q   <= tw_left_d;
            extra_q     <= extra_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            a_q         <= a_d;
            iorq_n_q    <= iorq_n_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            cd_out_q    <= cd_out_d;
            cd_oe_q     <= cd_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign A         = a_q;
    assign iorq_n    = iorq_n_q;
    assign rd_n      = rd_n_q;
    assign wr_n      = wr_n_q;
    assign cd_out    = cd_out_q;
    assign cd_oe     = cd_oe_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
